// File: rtl/mem_access_seq_pkg.sv
// Shared LC-3b memory-sequencer types: request record, sequencer state encoding
// and byte-lane helpers.
package lc3b_types;

  localparam int LC3B_DATA_WIDTH   = 16;
  localparam int LC3B_ADDR_WIDTH   = 16;
  localparam int LC3B_MAX_INDIRECT = 1;
  localparam int LC3B_IND_WIDTH    = $clog2(LC3B_MAX_INDIRECT + 1);

  function automatic int lc3b_byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

  localparam int LC3B_BYTE_LANES = lc3b_byte_lanes(LC3B_DATA_WIDTH);

  typedef struct packed {
    logic                       write;
    logic                       byte_acc;
    logic [LC3B_IND_WIDTH-1:0]  indirect;
    logic [LC3B_ADDR_WIDTH-1:0] addr;
    logic [LC3B_DATA_WIDTH-1:0] wdata;
  } lc3b_mem_req;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PTR_RD  = 3'd1,
    S_DATA_RD = 3'd2,
    S_DATA_WR = 3'd3,
    S_RESP    = 3'd4
  } lc3b_memseq_state;

endpackage

// File: rtl/mem_access_seq_byte_lane.sv
// Byte-lane steering: load-byte extraction (zero-extended), store-byte
// replication across all lanes, and one-hot write enable.
module mem_byte_lane
  import lc3b_types::*;
#(
  parameter int  DATA_WIDTH = 8 * LC3B_BYTE_LANES,
  localparam int NL         = lc3b_byte_lanes(DATA_WIDTH),
  localparam int LW         = $clog2(NL)
) (
  input  logic [LW-1:0]         i_lane,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [7:0]            i_wbyte,
  output logic [DATA_WIDTH-1:0] o_rbyte,
  output logic [DATA_WIDTH-1:0] o_wrep,
  output logic [NL-1:0]         o_byte_en
);

  always_comb begin
    o_rbyte      = '0;
    o_rbyte[7:0] = i_rdata[{i_lane, 3'b000} +: 8];
  end

  assign o_wrep    = {NL{i_wbyte}};
  assign o_byte_en = {{(NL-1){1'b0}}, 1'b1} << i_lane;

endmodule

// File: rtl/mem_access_seq.sv
// Memory-access sequencer between the multicycle control FSM and the memory port:
// pointer chasing, byte-lane steering and a per-access response timeout.
module mem_access_seq
  import lc3b_types::*;
#(
  parameter int  DATA_WIDTH     = 16,
  parameter int  ADDR_WIDTH     = 16,
  parameter int  MAX_INDIRECT   = 1,
  parameter int  TIMEOUT_CYCLES = 255,
  localparam int IW             = (MAX_INDIRECT < 1) ? 1 : $clog2(MAX_INDIRECT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic [IW-1:0]           req_indirect,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int NL = lc3b_byte_lanes(DATA_WIDTH);
  localparam int LW = $clog2(NL);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] MAX_IND  = IW'(MAX_INDIRECT);

  lc3b_memseq_state r_state, w_next;

  logic                  r_write;
  logic                  r_byte;
  logic [IW-1:0]         r_depth;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [TW-1:0]         r_tmo;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_error;

  logic                  w_access;
  logic                  w_tmo_hit;
  logic                  w_illegal;
  logic [ADDR_WIDTH-1:0] w_addr_even;
  logic [DATA_WIDTH-1:0] w_rbyte;
  logic [DATA_WIDTH-1:0] w_wrep;
  logic [NL-1:0]         w_byte_en;

  assign w_access    = (r_state == S_PTR_RD) || (r_state == S_DATA_RD) || (r_state == S_DATA_WR);
  // A response arriving on the last allowed cycle wins over the timeout.
  assign w_tmo_hit   = (TIMEOUT_CYCLES != 0) && w_access && !mem_resp && (r_tmo == TMO_LAST);
  assign w_illegal   = req_indirect > MAX_IND;
  assign w_addr_even = {r_addr[ADDR_WIDTH-1:1], 1'b0};

  mem_byte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_byte_lane (
    .i_lane   (r_addr[LW-1:0]),
    .i_rdata  (mem_rdata),
    .i_wbyte  (r_wdata[7:0]),
    .o_rbyte  (w_rbyte),
    .o_wrep   (w_wrep),
    .o_byte_en(w_byte_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_illegal)                 w_next = S_RESP;
          else if (req_indirect != '0)   w_next = S_PTR_RD;
          else if (req_write)            w_next = S_DATA_WR;
          else                           w_next = S_DATA_RD;
        end
      end
      S_PTR_RD: begin
        mem_read    = 1'b1;
        mem_address = w_addr_even;
        if (mem_resp) begin
          if (r_depth != IW'(1)) w_next = S_PTR_RD;
          else if (r_write)      w_next = S_DATA_WR;
          else                   w_next = S_DATA_RD;
        end else if (w_tmo_hit) begin
          w_next = S_RESP;
        end
      end
      S_DATA_RD: begin
        mem_read    = 1'b1;
        mem_address = r_byte ? r_addr : w_addr_even;
        if (mem_resp || w_tmo_hit) w_next = S_RESP;
      end
      S_DATA_WR: begin
        mem_write       = 1'b1;
        mem_address     = r_byte ? r_addr : w_addr_even;
        mem_wdata       = r_byte ? w_wrep : r_wdata;
        mem_byte_enable = r_byte ? w_byte_en : '1;
        if (mem_resp || w_tmo_hit) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_depth <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_tmo   <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      // Cleared outside access states and on every response, so each access starts from zero.
      r_tmo <= (w_access && !mem_resp) ? r_tmo + 1'b1 : '0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_byte  <= req_byte;
            r_depth <= req_indirect;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_illegal) r_error <= 1'b1;
          end
        end
        S_PTR_RD: begin
          if (mem_resp) begin
            r_addr  <= ADDR_WIDTH'(mem_rdata);
            r_depth <= r_depth - 1'b1;
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
          end
        end
        S_DATA_RD: begin
          if (mem_resp) begin
            r_rdata <= r_byte ? w_rbyte : mem_rdata;
            r_error <= 1'b0;
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
          end
        end
        S_DATA_WR: begin
          if (mem_resp)       r_error <= 1'b0;
          else if (w_tmo_hit) r_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: vector table of requests against a
// behavioural memory with programmable wait states, plus reset/timeout sequences.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [1:0]  req_indirect;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_byte_enable;

  mem_access_seq #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_INDIRECT(2), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_indirect(req_indirect), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // behavioural memory: word-keyed, responds after g_wait idle strobe cycles (-1 = never)
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } acc_t;

  logic [15:0] mem [logic [15:0]];
  acc_t        log_q[$];
  int          g_wait = 0;

  initial begin
    int          wcnt;
    logic [15:0] key, cur, nw;
    wcnt      = 0;
    mem_resp  = 1'b0;
    mem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = 16'hDEAD;
      if (mem_read || mem_write) begin
        if (g_wait >= 0 && wcnt == g_wait) begin
          key = mem_address & 16'hFFFE;
          cur = mem.exists(key) ? mem[key] : 16'h0000;
          if (mem_write) begin
            nw[7:0]  = mem_byte_enable[0] ? mem_wdata[7:0]  : cur[7:0];
            nw[15:8] = mem_byte_enable[1] ? mem_wdata[15:8] : cur[15:8];
            mem[key] = nw;
          end else begin
            mem_rdata = cur;
          end
          log_q.push_back('{mem_write, mem_address, mem_wdata, mem_byte_enable});
          mem_resp = 1'b1;
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic        byt;
    logic [1:0]  ind;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          wt;
    logic        err;
    logic [15:0] rdata;
    int          lat;
    int          nacc;
    int          strb;
    logic [15:0] laddr;
    logic [1:0]  be;
    logic [15:0] lwdata;
  } vec_t;

  task automatic do_req(input vec_t v, input int idx);
    int   c0, strb, lat, nlog0, nacc;
    logic seen, err;
    logic [15:0] rd;
    string tag;
    tag   = $sformatf("v%0d", idx);
    g_wait       = v.wt;
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_byte     = v.byt;
    req_indirect = v.ind;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    c0    = cyc;
    nlog0 = log_q.size();
    strb  = 0;
    lat   = 0;
    seen  = 1'b0;
    err   = 1'b0;
    rd    = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      if (mem_read || mem_write) strb++;
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = cyc - c0;
        err  = rsp_error;
        rd   = rsp_rdata;
      end
    end
    check({tag, " rsp_seen"}, seen, 1'b1);
    if (!seen) return;
    nacc = log_q.size() - nlog0;
    check({tag, " rsp_error"}, err, v.err);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " strobe_cycles"}, strb, v.strb);
    check({tag, " mem_accesses"}, nacc, v.nacc);
    if (!v.wr && !v.err) check({tag, " rsp_rdata"}, rd, v.rdata);
    if (nacc > 0) begin
      check({tag, " last_addr"}, log_q[$].addr, v.laddr);
      if (v.wr) begin
        check({tag, " byte_enable"}, log_q[$].be, v.be);
        check({tag, " mem_wdata"}, log_q[$].wdata, v.lwdata);
      end
    end
    @(negedge clk);
    check({tag, " ready_after"}, req_ready, 1'b1);
    check({tag, " pulse_one_cycle"}, rsp_valid, 1'b0);
  endtask

  vec_t vecs[15];
  vec_t vrec;

  initial begin
    int nrsp, nlog0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_indirect = '0; req_addr = '0; req_wdata = '0;
    mem[16'h1234] = 16'hBEEF;
    mem[16'h0040] = 16'h1122;
    mem[16'h3000] = 16'h4002;
    mem[16'h4002] = 16'h0077;
    mem[16'h5000] = 16'h3001;
    mem[16'h2000] = 16'h0000;

    //            wr    byt   ind    addr      wdata     wt  err   rdata    lat nacc strb laddr     be     lwdata
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 16'h1235, 16'h0000,  3, 1'b0, 16'hBEEF, 5, 1, 4, 16'h1234, 2'b00, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 16'h0041, 16'h00A5,  2, 1'b0, 16'h0000, 4, 1, 3, 16'h0041, 2'b10, 16'hA5A5};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 16'h0040, 16'h0000,  0, 1'b0, 16'hA522, 2, 1, 1, 16'h0040, 2'b00, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 16'h3000, 16'h0000,  0, 1'b0, 16'h0077, 3, 2, 2, 16'h4002, 2'b00, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 16'h5000, 16'h0000,  0, 1'b0, 16'h0077, 4, 3, 3, 16'h4002, 2'b00, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 16'h1235, 16'h0000,  0, 1'b0, 16'h00BE, 2, 1, 1, 16'h1235, 2'b00, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 16'h1234, 16'h0000,  1, 1'b0, 16'h00EF, 3, 1, 2, 16'h1234, 2'b00, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 16'h2001, 16'hCAFE,  0, 1'b0, 16'h0000, 2, 1, 1, 16'h2000, 2'b11, 16'hCAFE};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 16'h2000, 16'h0000,  0, 1'b0, 16'h00FE, 2, 1, 1, 16'h2000, 2'b00, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 16'h3000, 16'h1234,  0, 1'b0, 16'h0000, 3, 2, 2, 16'h4002, 2'b01, 16'h3434};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 16'h4002, 16'h0000,  0, 1'b0, 16'h0034, 2, 1, 1, 16'h4002, 2'b00, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 2'd3, 16'h1234, 16'h0000,  0, 1'b1, 16'h0000, 1, 0, 0, 16'h0000, 2'b00, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 16'h1234, 16'h0000, -1, 1'b1, 16'h0000, 5, 0, 4, 16'h0000, 2'b00, 16'h0000};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 16'h1234, 16'h0000,  4, 1'b1, 16'h0000, 5, 0, 4, 16'h0000, 2'b00, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 2'd1, 16'h3000, 16'h0000, -1, 1'b1, 16'h0000, 5, 0, 4, 16'h0000, 2'b00, 16'h0000};

    repeat (3) @(negedge clk);
    check("rst req_ready", req_ready, 1'b1);
    check("rst rsp_valid", rsp_valid, 1'b0);
    check("rst rsp_error", rsp_error, 1'b0);
    check("rst rsp_rdata", rsp_rdata, 16'h0000);
    check("rst mem_read", mem_read, 1'b0);
    check("rst mem_write", mem_write, 1'b0);
    check("rst mem_address", mem_address, 16'h0000);
    check("rst mem_wdata", mem_wdata, 16'h0000);
    check("rst byte_enable", mem_byte_enable, 2'b11);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) do_req(vecs[i], i);

    // reset while a store is stalled waiting for mem_resp
    g_wait = -1;
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_indirect = 2'd0;
    req_addr = 16'h2222; req_wdata = 16'h5555;
    nlog0 = log_q.size();
    @(negedge clk);
    req_valid = 1'b0;
    check("rstwr strobe_before", mem_write, 1'b1);
    @(negedge clk);
    check("rstwr addr_before", mem_address, 16'h2222);
    #2 reset = 1'b1;
    #1;
    check("rstwr mem_write_drop", mem_write, 1'b0);
    check("rstwr mem_read_drop", mem_read, 1'b0);
    check("rstwr req_ready", req_ready, 1'b1);
    check("rstwr rsp_valid", rsp_valid, 1'b0);
    check("rstwr rsp_error", rsp_error, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    nrsp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    check("rstwr no_response", nrsp, 0);
    check("rstwr no_mem_access", log_q.size() - nlog0, 0);

    vrec = '{1'b0, 1'b0, 2'd0, 16'h1234, 16'h0000, 0, 1'b0, 16'hBEEF, 2, 1, 1, 16'h1234, 2'b00, 16'h0000};
    do_req(vrec, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
